// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style LCD bus monitor: decodes EN strobes into commands/data, mirrors a 2x16
// DDRAM shadow, and flags short EN pulses and writes issued during the execution window.
module lcd_bus_monitor #(
   parameter int MIN_EN_HIGH       = 10,
   parameter int CMD_BUSY_CYCLES   = 2000,
   parameter int CLEAR_BUSY_CYCLES = 82000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  LCD_DATA,
   input  logic        LCD_RS,
   input  logic        LCD_RW,
   input  logic        LCD_EN,
   input  logic        err_clr,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_char,
   output logic [6:0]  cursor_addr,
   output logic        display_on,
   output logic        busy,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        cmd_rs,
   output logic [15:0] write_count,
   output logic        err_timing,
   output logic        err_busy
);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_EXEC} state_t;

   localparam int BW = (CLEAR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? $clog2(CLEAR_BUSY_CYCLES + 1)
                                                             : $clog2(CMD_BUSY_CYCLES + 1);
   localparam int PW = $clog2(MIN_EN_HIGH + 1);
   localparam logic [BW-1:0] CMD_LOAD  = BW'(CMD_BUSY_CYCLES - 1);
   localparam logic [BW-1:0] CLR_LOAD  = BW'(CLEAR_BUSY_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_MAX = PW'(MIN_EN_HIGH);

   // DDRAM address stepping: line 1 is 0x00-0x27, line 2 is 0x40-0x67, wrapping between them.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
      if (up) begin
         if (ac == 7'h27) return 7'h40;
         if (ac == 7'h67) return 7'h00;
         return ac + 7'd1;
      end
      if (ac == 7'h00) return 7'h67;
      if (ac == 7'h40) return 7'h27;
      return ac - 7'd1;
   endfunction

   logic          en_q, en_qq, rs_q, rw_q, lat_rs_q, lat_rw_q;
   logic [7:0]    data_q, lat_data_q;
   state_t        state_q, state_d;
   logic [PW-1:0] pulse_q, pulse_d;
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic [6:0]    ac_q, ac_d;
   logic          incr_q, incr_d, disp_q, disp_d, cgram_q, cgram_d;
   logic          cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
   logic [7:0]    cmd_byte_q, cmd_byte_d, rd_char_q;
   logic [15:0]   wcount_q, wcount_d;
   logic          err_timing_q, err_timing_d, err_busy_q, err_busy_d;
   logic          sweep_q, sweep_start;
   logic [4:0]    sweep_idx_q, wr_idx;
   logic          wr_en, long_busy, err_t_set, err_b_set, en_rise, en_fall;
   logic [7:0]    shadow_q [32];

   assign en_rise = en_q & ~en_qq;
   assign en_fall = ~en_q & en_qq;

   // The lat_* copies hold the bus as seen on the last EN-high cycle, ready at the fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q       <= 1'b0;
         en_qq      <= 1'b0;
         data_q     <= 8'h00;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         lat_data_q <= 8'h00;
         lat_rs_q   <= 1'b0;
         lat_rw_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         en_q   <= LCD_EN;
         en_qq  <= en_q;
         data_q <= LCD_DATA;
         rs_q   <= LCD_RS;
         rw_q   <= LCD_RW;
         if (en_q) begin
            lat_data_q <= data_q;
            lat_rs_q   <= rs_q;
            lat_rw_q   <= rw_q;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      state_d     = state_q;
      pulse_d     = pulse_q;
      busy_cnt_d  = busy_cnt_q;
      ac_d        = ac_q;
      incr_d      = incr_q;
      disp_d      = disp_q;
      cgram_d     = cgram_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      cmd_rs_d    = cmd_rs_q;
      wcount_d    = wcount_q;
      err_t_set   = 1'b0;
      err_b_set   = 1'b0;
      sweep_start = 1'b0;
      long_busy   = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = 5'd0;

      case (state_q)
         S_IDLE: begin
            if (en_rise) begin
               state_d = S_PULSE;
               pulse_d = PW'(1);
            end
         end
         S_EXEC: begin
            if (en_rise) begin
               err_b_set = 1'b1;
               state_d   = S_PULSE;
               pulse_d   = PW'(1);
            end else if (busy_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               busy_cnt_d = busy_cnt_q - 1'b1;
            end
         end
         S_PULSE: begin
            if (en_fall && lat_rw_q) begin
               state_d = S_IDLE;
            end else if (en_fall) begin
               cmd_valid_d = 1'b1;
               cmd_byte_d  = lat_data_q;
               cmd_rs_d    = lat_rs_q;
               err_t_set   = (pulse_q < PULSE_MAX);
               if (lat_rs_q) begin
                  if (!cgram_q) begin
                     wr_en  = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
                     wr_idx = {ac_q[6], ac_q[3:0]};
                     ac_d   = ac_step(ac_q, incr_q);
                  end
                  wcount_d = wcount_q + 16'd1;
               end else begin
                  casez (lat_data_q)
                     8'b1???????: begin ac_d = lat_data_q[6:0]; cgram_d = 1'b0; end
                     8'b01??????: cgram_d = 1'b1;
                     8'b001?????: ;
                     8'b0001????: if (!lat_data_q[3]) ac_d = ac_step(ac_q, lat_data_q[2]);
                     8'b00001???: disp_d = lat_data_q[2];
                     8'b000001??: incr_d = lat_data_q[1];
                     8'b0000001?: begin ac_d = 7'h00; long_busy = 1'b1; end
                     8'b00000001: begin
                        ac_d        = 7'h00;
                        incr_d      = 1'b1;
                        long_busy   = 1'b1;
                        sweep_start = 1'b1;
                     end
                     default: ;
                  endcase
               end
               state_d    = S_EXEC;
               busy_cnt_d = long_busy ? CLR_LOAD : CMD_LOAD;
            end else if (en_q && (pulse_q < PULSE_MAX)) begin
               pulse_d = pulse_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      err_timing_d = err_t_set | (err_timing_q & ~err_clr);
      err_busy_d   = err_b_set | (err_busy_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pulse_q      <= '0;
         busy_cnt_q   <= '0;
         ac_q         <= 7'h00;
         incr_q       <= 1'b1;
         disp_q       <= 1'b0;
         cgram_q      <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= 8'h00;
         cmd_rs_q     <= 1'b0;
         wcount_q     <= 16'h0000;
         err_timing_q <= 1'b0;
         err_busy_q   <= 1'b0;
         sweep_q      <= 1'b0;
         sweep_idx_q  <= 5'd0;
      end else begin
         state_q      <= state_d;
         pulse_q      <= pulse_d;
         busy_cnt_q   <= busy_cnt_d;
         ac_q         <= ac_d;
         incr_q       <= incr_d;
         disp_q       <= disp_d;
         cgram_q      <= cgram_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_byte_q   <= cmd_byte_d;
         cmd_rs_q     <= cmd_rs_d;
         wcount_q     <= wcount_d;
         err_timing_q <= err_timing_d;
         err_busy_q   <= err_busy_d;
         if (sweep_start) begin
            sweep_q     <= 1'b1;
            sweep_idx_q <= 5'd0;
         end else if (sweep_q) begin
            sweep_q     <= (sweep_idx_q != 5'd31);
            sweep_idx_q <= sweep_idx_q + 5'd1;
         end
      end
   end

   // A data write landing on the entry the sweep is clearing wins, since it is the newer value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the 32-entry shadow is reset as flops so the mirror starts as blank spaces.
         for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
         rd_char_q <= 8'h20;
      end else begin
         if (sweep_q) shadow_q[sweep_idx_q] <= 8'h20;
         if (wr_en) shadow_q[wr_idx] <= lat_data_q;
         rd_char_q <= shadow_q[rd_addr];
      end
   end

   assign rd_char     = rd_char_q;
   assign cursor_addr = ac_q;
   assign display_on  = disp_q;
   assign busy        = (state_q == S_EXEC);
   assign cmd_valid   = cmd_valid_q;
   assign cmd_byte    = cmd_byte_q;
   assign cmd_rs      = cmd_rs_q;
   assign write_count = wcount_q;
   assign err_timing  = err_timing_q;
   assign err_busy    = err_busy_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: init sequence, DDRAM mirror, cursor wrap, EN timing and busy errors.
module tb_lcd_bus_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  LCD_DATA;
   logic        LCD_RS, LCD_RW, LCD_EN, err_clr;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_char, cmd_byte;
   logic [6:0]  cursor_addr;
   logic        display_on, busy, cmd_valid, cmd_rs, err_timing, err_busy;
   logic [15:0] write_count;

   int total = 0;
   int bad   = 0;

   lcd_bus_monitor #(
      .MIN_EN_HIGH      (10),
      .CMD_BUSY_CYCLES  (50),
      .CLEAR_BUSY_CYCLES(500)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .LCD_DATA   (LCD_DATA),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_EN     (LCD_EN),
      .err_clr    (err_clr),
      .rd_addr    (rd_addr),
      .rd_char    (rd_char),
      .cursor_addr(cursor_addr),
      .display_on (display_on),
      .busy       (busy),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .cmd_rs     (cmd_rs),
      .write_count(write_count),
      .err_timing (err_timing),
      .err_busy   (err_busy)
   );

   always #5 clk = ~clk;

   // EN is sampled high on exactly 'hi' rising edges; returns just after EN is dropped.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi);
      @(posedge clk); #1;
      LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
      repeat (hi) @(posedge clk);
      #1 LCD_EN = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      repeat (3) @(posedge clk);
      #1;
      while (busy === 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
         bad++;
      end
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      strobe(rs, 1'b0, d, 10);
      wait_idle(1000);
   endtask

   task automatic read_buf(input int a, output logic [7:0] v);
      @(posedge clk); #1 rd_addr = 5'(a);
      @(posedge clk); #1 v = rd_char;
   endtask

   task automatic pulse_err_clr();
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; LCD_DATA = 8'h00; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_EN = 1'b0;
      err_clr = 1'b0; rd_addr = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (rd_char !== 8'h20) begin $display("FAIL reset_rd_char: got %h required 20", rd_char); bad++; end
      total++;
      if (cursor_addr !== 7'h00) begin $display("FAIL reset_cursor: got %h required 00", cursor_addr); bad++; end
      total++;
      if ({display_on, busy, cmd_valid, cmd_rs, err_timing, err_busy} !== 6'b0) begin
         $display("FAIL reset_flags: got %b required 000000",
                  {display_on, busy, cmd_valid, cmd_rs, err_timing, err_busy});
         bad++;
      end
      total++;
      if ({cmd_byte, write_count} !== 24'h0) begin
         $display("FAIL reset_counts: cmd_byte=%h write_count=%h required 0", cmd_byte, write_count); bad++;
      end
      @(posedge clk); #1 reset = 1'b1;
   endtask

   task automatic test_init();
      logic [7:0] v;
      strobe(1'b0, 1'b0, 8'h38, 10);
      @(posedge clk); #1;
      total++;
      if ({cmd_valid, busy} !== 2'b00) begin $display("FAIL init_early: valid,busy=%b required 00", {cmd_valid, busy}); bad++; end
      @(posedge clk); #1;
      total++;
      if ({cmd_valid, busy, cmd_byte} !== {2'b11, 8'h38}) begin
         $display("FAIL init_cmd_valid: valid,busy=%b byte=%h required 11 38", {cmd_valid, busy}, cmd_byte); bad++;
      end
      repeat (49) @(posedge clk);
      #1;
      total++;
      if ({cmd_valid, busy} !== 2'b01) begin $display("FAIL init_busy_len: valid,busy=%b required 01", {cmd_valid, busy}); bad++; end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin $display("FAIL init_busy_end: busy=%b required 0", busy); bad++; end
      wr(1'b0, 8'h0C);
      wr(1'b0, 8'h01);
      wr(1'b0, 8'h06);
      total++;
      if ({display_on, err_timing, err_busy, cursor_addr} !== {3'b100, 7'h00}) begin
         $display("FAIL init_state: disp,errt,errb=%b ac=%h required 100 00",
                  {display_on, err_timing, err_busy}, cursor_addr); bad++;
      end
      for (int i = 0; i < 32; i++) begin
         read_buf(i, v);
         total++;
         if (v !== 8'h20) begin $display("FAIL init_buf[%0d]: got %h required 20", i, v); bad++; end
      end
   endtask

   task automatic test_data_write();
      logic [7:0] v;
      logic [7:0] exp_chars [4];
      exp_chars = '{8'h4C, 8'h4F, 8'h41, 8'h44};
      for (int i = 0; i < 4; i++) wr(1'b1, exp_chars[i]);
      for (int i = 0; i < 4; i++) begin
         read_buf(i, v);
         total++;
         if (v !== exp_chars[i]) begin $display("FAIL load_buf[%0d]: got %h required %h", i, v, exp_chars[i]); bad++; end
      end
      total++;
      if ({cursor_addr, write_count, cmd_rs, cmd_byte} !== {7'h04, 16'd4, 1'b1, 8'h44}) begin
         $display("FAIL load_state: ac=%h wc=%0d rs=%b byte=%h required 04 4 1 44",
                  cursor_addr, write_count, cmd_rs, cmd_byte); bad++;
      end
   endtask

   task automatic test_line2();
      logic [7:0] v;
      wr(1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h61 + i));
      for (int i = 0; i < 16; i++) begin
         read_buf(16 + i, v);
         total++;
         if (v !== 8'(8'h61 + i)) begin $display("FAIL line2_buf[%0d]: got %h required %h", 16 + i, v, 8'(8'h61 + i)); bad++; end
      end
      total++;
      if (cursor_addr !== 7'h50) begin $display("FAIL line2_ac: got %h required 50", cursor_addr); bad++; end
      wr(1'b0, 8'hA7);
      wr(1'b1, 8'h5A);
      total++;
      if ({cursor_addr, write_count} !== {7'h40, 16'd21}) begin
         $display("FAIL discard: ac=%h wc=%0d required 40 21", cursor_addr, write_count); bad++;
      end
      read_buf(7, v);
      total++;
      if (v !== 8'h20) begin $display("FAIL discard_buf7: got %h required 20", v); bad++; end
      wr(1'b0, 8'h80);
      wr(1'b0, 8'h10);
      total++;
      if (cursor_addr !== 7'h67) begin $display("FAIL dec_wrap_00: got %h required 67", cursor_addr); bad++; end
   endtask

   task automatic test_cursor_moves();
      logic [7:0] v;
      wr(1'b0, 8'h14);
      total++;
      if (cursor_addr !== 7'h00) begin $display("FAIL inc_wrap_67: got %h required 00", cursor_addr); bad++; end
      wr(1'b0, 8'hC0);
      wr(1'b0, 8'h10);
      total++;
      if (cursor_addr !== 7'h27) begin $display("FAIL dec_wrap_40: got %h required 27", cursor_addr); bad++; end
      wr(1'b0, 8'h14);
      total++;
      if (cursor_addr !== 7'h40) begin $display("FAIL inc_wrap_27: got %h required 40", cursor_addr); bad++; end
      wr(1'b0, 8'h04);
      wr(1'b0, 8'h81);
      wr(1'b1, 8'h78);
      wr(1'b1, 8'h79);
      read_buf(1, v);
      total++;
      if (v !== 8'h78) begin $display("FAIL dec_buf1: got %h required 78", v); bad++; end
      read_buf(0, v);
      total++;
      if ({v, cursor_addr, write_count} !== {8'h79, 7'h67, 16'd23}) begin
         $display("FAIL dec_data: buf0=%h ac=%h wc=%0d required 79 67 23", v, cursor_addr, write_count); bad++;
      end
      wr(1'b0, 8'h06);
      wr(1'b0, 8'h85);
      wr(1'b0, 8'h40);
      wr(1'b1, 8'h71);
      read_buf(5, v);
      total++;
      if ({v, cursor_addr, write_count} !== {8'h20, 7'h05, 16'd24}) begin
         $display("FAIL cgram_discard: buf5=%h ac=%h wc=%0d required 20 05 24", v, cursor_addr, write_count); bad++;
      end
      wr(1'b0, 8'h85);
      wr(1'b1, 8'h72);
      wr(1'b0, 8'h18);
      read_buf(5, v);
      total++;
      if ({v, cursor_addr, write_count} !== {8'h72, 7'h06, 16'd25}) begin
         $display("FAIL cgram_exit: buf5=%h ac=%h wc=%0d required 72 06 25", v, cursor_addr, write_count); bad++;
      end
   endtask

   task automatic test_timing();
      logic seen;
      wr(1'b0, 8'h08);
      strobe(1'b0, 1'b0, 8'h0C, 3);
      wait_idle(1000);
      total++;
      if ({err_timing, display_on} !== 2'b11) begin $display("FAIL short_pulse: errt,disp=%b required 11", {err_timing, display_on}); bad++; end
      pulse_err_clr();
      #1;
      total++;
      if (err_timing !== 1'b0) begin $display("FAIL err_clr_timing: got %b required 0", err_timing); bad++; end
      wr(1'b0, 8'h08);
      total++;
      if ({err_timing, display_on} !== 2'b00) begin $display("FAIL pulse_exact_min: errt,disp=%b required 00", {err_timing, display_on}); bad++; end
      strobe(1'b0, 1'b0, 8'h0C, 9);
      wait_idle(1000);
      total++;
      if ({err_timing, display_on} !== 2'b11) begin $display("FAIL pulse_min_minus1: errt,disp=%b required 11", {err_timing, display_on}); bad++; end
      pulse_err_clr();
      strobe(1'b0, 1'b1, 8'h08, 10);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (cmd_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      total++;
      if ({seen, display_on} !== 2'b01) begin $display("FAIL rw_read_ignored: activity,disp=%b required 01", {seen, display_on}); bad++; end
      LCD_RW = 1'b0;
   endtask

   task automatic test_busy_err();
      strobe(1'b0, 1'b0, 8'h01, 10);
      repeat (100) @(posedge clk);
      #1;
      total++;
      if ({busy, err_busy} !== 2'b10) begin $display("FAIL clear_window: busy,errb=%b required 10", {busy, err_busy}); bad++; end
      strobe(1'b0, 1'b0, 8'h0C, 10);
      total++;
      if (err_busy !== 1'b1) begin $display("FAIL err_busy_set: got %b required 1", err_busy); bad++; end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, cmd_valid, cmd_byte} !== {2'b11, 8'h0C}) begin
         $display("FAIL busy_restart: busy,valid=%b byte=%h required 11 0C", {busy, cmd_valid}, cmd_byte); bad++;
      end
      repeat (55) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin $display("FAIL busy_restart_len: busy=%b required 0", busy); bad++; end
      strobe(1'b0, 1'b0, 8'h01, 10);
      repeat (5) @(posedge clk);
      #1;
      LCD_RS = 1'b0; LCD_DATA = 8'h0C; LCD_EN = 1'b1;
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      repeat (8) @(posedge clk);
      #1 LCD_EN = 1'b0;
      total++;
      if (err_busy !== 1'b1) begin $display("FAIL set_beats_clr: got %b required 1", err_busy); bad++; end
      wait_idle(1000);
      pulse_err_clr();
      #1;
      total++;
      if ({err_busy, err_timing} !== 2'b00) begin $display("FAIL err_clr_both: errb,errt=%b required 00", {err_busy, err_timing}); bad++; end
   endtask

   task automatic test_reset_sweep();
      logic [7:0] v;
      wr(1'b0, 8'h80);
      for (int i = 0; i < 4; i++) wr(1'b1, 8'(8'h57 + i));
      wr(1'b0, 8'hC0);
      for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h41 + i));
      strobe(1'b0, 1'b0, 8'h01, 10);
      repeat (8) @(posedge clk);
      #1;
      read_buf(31, v);
      total++;
      if (v !== 8'h50) begin $display("FAIL sweep_not_reached: buf31=%h required 50", v); bad++; end
      read_buf(2, v);
      total++;
      if (v !== 8'h20) begin $display("FAIL sweep_reached: buf2=%h required 20", v); bad++; end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      total++;
      if ({busy, display_on, cmd_valid, cursor_addr, cmd_byte, write_count, rd_char} !==
          {3'b000, 7'h00, 8'h00, 16'h0000, 8'h20}) begin
         $display("FAIL reset_mid_sweep: busy,disp,valid=%b ac=%h byte=%h wc=%h rd=%h",
                  {busy, display_on, cmd_valid}, cursor_addr, cmd_byte, write_count, rd_char); bad++;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin $display("FAIL reset_abort_busy: got %b required 0", busy); bad++; end
      for (int i = 0; i < 32; i++) begin
         read_buf(i, v);
         total++;
         if (v !== 8'h20) begin $display("FAIL reset_buf[%0d]: got %h required 20", i, v); bad++; end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_data_write();
      test_line2();
      test_cursor_moves();
      test_timing();
      test_busy_err();
      test_reset_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
